// File: rtl/sseg_scan_driver_pkg.sv
// Purpose: shared constants and BCD-to-segment lookup for the scan driver.
// Latency: n/a (constants and a pure function only).
// Backpressure: n/a.
// Contents: DP bit position, active-low patterns 0-9, DASH, BLANK, bcd_to_seg().
package sseg_pkg;

  localparam int DP = 7;

  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h98;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // Active-low pattern, dp unlit; non-decimal codes render as a dash.
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    logic [7:0] pat;
    case (bcd)
      4'd0:    pat = SEG_0;
      4'd1:    pat = SEG_1;
      4'd2:    pat = SEG_2;
      4'd3:    pat = SEG_3;
      4'd4:    pat = SEG_4;
      4'd5:    pat = SEG_5;
      4'd6:    pat = SEG_6;
      4'd7:    pat = SEG_7;
      4'd8:    pat = SEG_8;
      4'd9:    pat = SEG_9;
      default: pat = SEG_DASH;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/sseg_scan_driver_if.sv
// Purpose: display request bundle and board pin bundle for the scan driver.
// Latency: n/a (wires only).
// Backpressure: none; display requests are level signals sampled once per frame.
// master = timekeeping/setup side (drives requests, sees pins);
// slave  = scan driver (consumes requests, drives SSEG/SSEGD/SSEG_COL).
interface sseg_scan_driver_if #(
  parameter int NUM_DIGITS = 4
);
  logic [4*NUM_DIGITS-1:0] digits_in;
  logic [NUM_DIGITS-1:0]   dp_in;
  logic [NUM_DIGITS-1:0]   blink_mask;
  logic                    blank_lead;
  logic                    colon_en;
  logic                    colon_blink;
  logic [7:0]              SSEG;
  logic [NUM_DIGITS-1:0]   SSEGD;
  logic                    SSEG_COL;

  modport master (
    output digits_in, dp_in, blink_mask, blank_lead, colon_en, colon_blink,
    input  SSEG, SSEGD, SSEG_COL
  );

  modport slave (
    input  digits_in, dp_in, blink_mask, blank_lead, colon_en, colon_blink,
    output SSEG, SSEGD, SSEG_COL
  );
endinterface

// File: rtl/sseg_scan_driver_decode.sv
// Purpose: final 8-bit segment pattern for the digit in the current slot.
// Latency: combinational.
// Backpressure: none.
// Ports: bcd/dp/blank in, active_low selects pin polarity, seg out (bit 7 = dp).
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       dp,
  input  logic       blank,
  input  logic       active_low,
  output logic [7:0] seg
);

  logic [7:0] pat;

  always_comb begin
    pat = bcd_to_seg(bcd);
    if (dp) begin
      pat[DP] = 1'b0;
    end
    // Blank wins over everything, decimal point included.
    if (blank) begin
      pat = SEG_BLANK;
    end
    seg = active_low ? pat : ~pat;
  end

endmodule

// File: rtl/sseg_scan_driver.sv
// Purpose: multiplexed seven-segment scan with blink, colon, lead-zero blanking.
// Latency: input change reaches the pins at the next frame start (<= 1 frame).
// Backpressure: none; inputs are sampled, never stalled.
// Ports: clk, rst_n (async, active-low), bus (slave modport: requests in, pins out).
module sseg_scan_driver
  import sseg_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 12500,
  parameter int BLINK_DIV  = 25,
  parameter int ACTIVE_LOW = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  sseg_scan_driver_if.slave bus
);

  localparam int DIV_W = (SCAN_DIV   > 1) ? $clog2(SCAN_DIV)   : 1;
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BLK_W = (BLINK_DIV  > 1) ? $clog2(BLINK_DIV)  : 1;

  localparam logic                  AL       = (ACTIVE_LOW != 0);
  localparam logic [7:0]            SSEG_OFF = AL ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] EN_OFF   = {NUM_DIGITS{AL}};
  localparam logic                  COL_OFF  = AL;

  logic [DIV_W-1:0]        div_cnt_q, div_cnt_d;
  logic [IDX_W-1:0]        scan_idx_q, scan_idx_d;
  logic [BLK_W-1:0]        blink_cnt_q, blink_cnt_d;
  logic                    blink_phase_q, blink_phase_d;

  // Per-frame snapshot; blink phase is included so a frame never changes
  // its blink state halfway through.
  logic [4*NUM_DIGITS-1:0] sh_digits_q, sh_digits_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_mask_q, sh_mask_d;
  logic                    sh_lead_q, sh_lead_d;
  logic                    sh_phase_q, sh_phase_d;

  logic [7:0]              sseg_q, sseg_d;
  logic [NUM_DIGITS-1:0]   ssegd_q, ssegd_d;
  logic                    col_q, col_d;

  logic                    tick;
  logic                    frame_start;
  logic [4*NUM_DIGITS-1:0] src_digits;
  logic [NUM_DIGITS-1:0]   src_dp;
  logic [NUM_DIGITS-1:0]   src_mask;
  logic                    src_lead;
  logic                    src_phase;
  logic [NUM_DIGITS-1:0]   lead_zero;
  logic                    zero_run;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              slot_bcd;
  logic                    slot_dp;
  logic                    slot_blank;
  logic                    col_lit;
  logic [7:0]              dec_seg;

  // Divider, scan index, blink counter.
  always_comb begin
    tick        = (div_cnt_q == DIV_W'(SCAN_DIV - 1));
    frame_start = tick && (scan_idx_q == '0);

    div_cnt_d = tick ? '0 : div_cnt_q + 1'b1;

    scan_idx_d = scan_idx_q;
    if (tick) begin
      scan_idx_d = (scan_idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx_q + 1'b1;
    end

    blink_cnt_d   = blink_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (blink_cnt_q == BLK_W'(BLINK_DIV - 1)) begin
        blink_cnt_d   = '0;
        blink_phase_d = ~blink_phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
  end

  // Digit 0 reads the live inputs (the same values being captured), every
  // later slot reads the snapshot, so a frame is always self-consistent.
  always_comb begin
    src_digits = frame_start ? bus.digits_in  : sh_digits_q;
    src_dp     = frame_start ? bus.dp_in      : sh_dp_q;
    src_mask   = frame_start ? bus.blink_mask : sh_mask_q;
    src_lead   = frame_start ? bus.blank_lead : sh_lead_q;
    src_phase  = frame_start ? blink_phase_q  : sh_phase_q;

    sh_digits_d = src_digits;
    sh_dp_d     = src_dp;
    sh_mask_d   = src_mask;
    sh_lead_d   = src_lead;
    sh_phase_d  = src_phase;
  end

  // Lead-zero prefix: digit i blanks only if every digit to its left and
  // itself are zero; the rightmost digit always shows.
  always_comb begin
    zero_run  = 1'b1;
    lead_zero = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      zero_run     = zero_run && (src_digits[4*i +: 4] == 4'd0);
      lead_zero[i] = src_lead && zero_run && (i < NUM_DIGITS - 1);
    end
  end

  // Slot mux onto the single decoder.
  always_comb begin
    slot_bcd   = 4'd0;
    slot_dp    = 1'b0;
    slot_blank = 1'b0;
    onehot     = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx_q == IDX_W'(i)) begin
        onehot[i]  = 1'b1;
        slot_bcd   = src_digits[4*i +: 4];
        slot_dp    = src_dp[i];
        slot_blank = (src_mask[i] && src_phase) || lead_zero[i];
      end
    end
    col_lit = bus.colon_en && !(bus.colon_blink && src_phase);
  end

  sseg_decode u_decode (
    .bcd        (slot_bcd),
    .dp         (slot_dp),
    .blank      (slot_blank),
    .active_low (AL),
    .seg        (dec_seg)
  );

  // Pin registers change only on tick.
  always_comb begin
    sseg_d  = sseg_q;
    ssegd_d = ssegd_q;
    col_d   = col_q;
    if (tick) begin
      sseg_d  = dec_seg;
      ssegd_d = AL ? ~onehot : onehot;
      col_d   = col_lit ^ COL_OFF;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q     <= '0;
      scan_idx_q    <= '0;
      blink_cnt_q   <= '0;
      blink_phase_q <= 1'b0;
      sh_digits_q   <= '0;
      sh_dp_q       <= '0;
      sh_mask_q     <= '0;
      sh_lead_q     <= 1'b0;
      sh_phase_q    <= 1'b0;
      sseg_q        <= SSEG_OFF;
      ssegd_q       <= EN_OFF;
      col_q         <= COL_OFF;
    end else begin
      div_cnt_q     <= div_cnt_d;
      scan_idx_q    <= scan_idx_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_phase_q <= blink_phase_d;
      sh_digits_q   <= sh_digits_d;
      sh_dp_q       <= sh_dp_d;
      sh_mask_q     <= sh_mask_d;
      sh_lead_q     <= sh_lead_d;
      sh_phase_q    <= sh_phase_d;
      sseg_q        <= sseg_d;
      ssegd_q       <= ssegd_d;
      col_q         <= col_d;
    end
  end

  assign bus.SSEG     = sseg_q;
  assign bus.SSEGD    = ssegd_q;
  assign bus.SSEG_COL = col_q;

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Purpose: self-checking bench for sseg_scan_driver (4 digits, SCAN_DIV=4, BLINK_DIV=2).
// Latency: n/a.
// Backpressure: n/a.
module tb_sseg_scan_driver;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int BD = 2;

  logic clk = 1'b0;
  logic rst_n;

  sseg_scan_driver_if #(.NUM_DIGITS(ND)) bus();

  sseg_scan_driver #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (SD),
    .BLINK_DIV  (BD),
    .ACTIVE_LOW (1)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;
  int rel = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] seg_of(input logic [3:0] v);
    logic [7:0] tab [0:9];
    tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8, 8'h80, 8'h98};
    return (v <= 4'd9) ? tab[v] : 8'hBF;
  endfunction

  // Model: from the edge count since reset, slot k (0-based) ends on edge
  // SD*(k+1); its digit is k%ND, its frame k/ND, blink phase (frame/BD)%2.
  int         m_e = 0;
  int         m_t, m_d, m_f;
  bit         m_ph, m_allz;
  logic [15:0] sn_dig = '0;
  logic [3:0]  sn_dp = '0, sn_mask = '0;
  logic        sn_lead = 1'b0;
  logic [7:0]  m_pat;
  logic [7:0]  ex_sseg = 8'hFF;
  logic [3:0]  ex_en = 4'hF;
  logic        ex_col = 1'b1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e = 0; ex_sseg = 8'hFF; ex_en = 4'hF; ex_col = 1'b1;
    end else begin
      m_e++;
      if (m_e % SD == 0) begin
        m_t = m_e / SD - 1;
        m_d = m_t % ND;
        m_f = m_t / ND;
        if (m_d == 0) begin
          sn_dig = bus.digits_in; sn_dp = bus.dp_in;
          sn_mask = bus.blink_mask; sn_lead = bus.blank_lead;
        end
        m_ph  = ((m_f / BD) % 2) == 1;
        m_pat = seg_of(sn_dig[4*m_d +: 4]);
        if (sn_dp[m_d]) m_pat[7] = 1'b0;
        m_allz = 1'b1;
        for (int j = 0; j <= m_d; j++)
          if (sn_dig[4*j +: 4] != 4'd0) m_allz = 1'b0;
        if ((sn_mask[m_d] && m_ph) || (sn_lead && m_d < ND - 1 && m_allz))
          m_pat = 8'hFF;
        ex_sseg = m_pat;
        ex_en   = ~(4'b0001 << m_d);
        ex_col  = !(bus.colon_en && !(bus.colon_blink && m_ph));
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("model_sseg", {24'd0, bus.SSEG}, {24'd0, ex_sseg});
      chk("model_ssegd", {28'd0, bus.SSEGD}, {28'd0, ex_en});
      chk("model_col", {31'd0, bus.SSEG_COL}, {31'd0, ex_col});
      if (m_e >= SD) chk("onehot", $countones(~bus.SSEGD), 32'd1);
    end
  end

  // Advance to the given edge count after reset release, then settle 1.
  task automatic at_edge(input int target);
    while (rel < target) begin
      @(posedge clk);
      rel++;
    end
    #1;
  endtask

  task automatic lit(input string nm, input logic [7:0] s, input logic [3:0] e);
    chk({nm, "_sseg"}, {24'd0, bus.SSEG}, {24'd0, s});
    chk({nm, "_ssegd"}, {28'd0, bus.SSEGD}, {28'd0, e});
  endtask

  initial begin
    rst_n = 1'b0;
    bus.digits_in   = 16'h4321;
    bus.dp_in       = 4'b0000;
    bus.blink_mask  = 4'b0010;
    bus.blank_lead  = 1'b0;
    bus.colon_en    = 1'b1;
    bus.colon_blink = 1'b1;
    #1 chk_on = 1'b1;
    repeat (3) @(negedge clk);
    lit("reset", 8'hFF, 4'hF);
    chk("reset_col", {31'd0, bus.SSEG_COL}, 32'd1);
    rst_n = 1'b1;
    rel = 0;

    // First update and scan order.
    at_edge(3);  chk("pre_first_ssegd", {28'd0, bus.SSEGD}, 32'hF);
    at_edge(4);  lit("d0_f0", 8'hF9, 4'b1110);
    chk("col_f0", {31'd0, bus.SSEG_COL}, 32'd0);
    at_edge(8);  lit("d1_f0", 8'hA4, 4'b1101);
    at_edge(12); lit("d2_f0", 8'hB0, 4'b1011);
    at_edge(16); lit("d3_f0", 8'h99, 4'b0111);
    at_edge(20); lit("d0_f1", 8'hF9, 4'b1110);
    at_edge(24); lit("d1_f1", 8'hA4, 4'b1101);

    // Blink: frame 2 is the first off half.
    at_edge(36); lit("d0_f2", 8'hF9, 4'b1110);
    chk("col_f2", {31'd0, bus.SSEG_COL}, 32'd1);
    at_edge(40); lit("d1_f2", 8'hFF, 4'b1101);
    at_edge(72); lit("d1_f4", 8'hA4, 4'b1101);
    chk("col_f4", {31'd0, bus.SSEG_COL}, 32'd0);

    // Leading-zero blanking.
    bus.blink_mask = 4'b0000; bus.colon_blink = 1'b0;
    bus.blank_lead = 1'b1; bus.digits_in = 16'h5400;
    at_edge(84); lit("lz_d0", 8'hFF, 4'b1110);
    at_edge(88); lit("lz_d1", 8'hFF, 4'b1101);
    at_edge(92); lit("lz_d2", 8'h99, 4'b1011);
    at_edge(96); lit("lz_d3", 8'h92, 4'b0111);
    bus.digits_in = 16'h0000;
    at_edge(100); lit("z_d0", 8'hFF, 4'b1110);
    at_edge(108); lit("z_d2", 8'hFF, 4'b1011);
    at_edge(112); lit("z_d3", 8'hC0, 4'b0111);

    // Invalid code with decimal point.
    bus.digits_in = 16'h0C00; bus.dp_in = 4'b0100;
    at_edge(124); lit("dash_dp", 8'h3F, 4'b1011);
    at_edge(128); lit("dash_d3", 8'hC0, 4'b0111);

    // Mid-frame change stays out of the current frame.
    bus.digits_in = 16'h8765; bus.dp_in = 4'b0000; bus.blank_lead = 1'b0;
    at_edge(132); lit("cap_d0", 8'h92, 4'b1110);
    at_edge(140); lit("cap_d2", 8'hF8, 4'b1011);
    bus.digits_in = 16'h4321;
    at_edge(144); lit("cap_d3_old", 8'h80, 4'b0111);
    at_edge(148); lit("cap_d0_new", 8'hF9, 4'b1110);
    at_edge(152); lit("cap_d1_new", 8'hA4, 4'b1101);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1 lit("arst", 8'hFF, 4'hF);
    chk("arst_col", {31'd0, bus.SSEG_COL}, 32'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    rel = 0;
    at_edge(3); lit("rst2_pre", 8'hFF, 4'hF);
    at_edge(4); lit("rst2_d0", 8'hF9, 4'b1110);
    at_edge(8); lit("rst2_d1", 8'hA4, 4'b1101);

    @(negedge clk);
    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule

// File: doc/sseg_scan_driver.md
# sseg_scan_driver

Parametrised multiplexed seven-segment scan driver for the clock display path. It time-multiplexes `NUM_DIGITS` BCD digits onto one shared segment bus. Beyond the fixed four-digit driver it adds:
- per-digit blink for setup mode
- decimal-point and colon control with blink
- leading-zero blanking
- an invalid-code indicator
- frame-consistent input capture

It sits between the timekeeping/setup logic and the board's `SSEG`/`SSEGD`/`SSEG_COL` pins.

## Interface
Parameters:
- `NUM_DIGITS`, 4: digits scanned, legal range 1..8.
- `SCAN_DIV`, 12500: `clk` cycles per digit slot, minimum 2.
- `BLINK_DIV`, 25: frames per blink half-period, minimum 1.
- `ACTIVE_LOW`, 1: 1 means segment, enable and colon outputs light at 0; 0 inverts all three.

Ports:
- `clk` in 1: system clock. One clock domain.
- `rst_n` in 1: reset, asynchronous assert, active-low.
- `digits_in` in 4*NUM_DIGITS: BCD. Digit i is at `[4*i+3:4*i]`. Digit 0 is leftmost.
- `dp_in` in NUM_DIGITS: decimal point request per digit.
- `blink_mask` in NUM_DIGITS: 1 makes that digit blink.
- `blank_lead` in 1: enable leading-zero suppression.
- `colon_en` in 1: colon on.
- `colon_blink` in 1: colon follows the blink phase.
- `SSEG` out 8: bit 7 = dp, bits 6:0 = g..a.
- `SSEGD` out NUM_DIGITS: digit enables. `SSEGD[i]` drives digit i.
- `SSEG_COL` out 1: colon.

## Operation
- **Divider.** `div_cnt` counts 0..SCAN_DIV-1 and wraps. `tick` = (`div_cnt` == SCAN_DIV-1).
- **Scan index.** `scan_idx` is the digit shown at the next tick. On each `tick`, it advances and wraps NUM_DIGITS-1 to 0.
- **Frame start.** This is a `tick` with `scan_idx` == 0. On it:
  - `shadow` <= `digits_in`, `dp_in`, `blink_mask`, `blank_lead`.
  - Digit 0 decodes from the live inputs, so every frame is self-consistent.
  - Input changes mid-frame never appear until the next frame.
- **Blink.** `blink_cnt` increments at each frame start. When it wraps at BLINK_DIV-1, `blink_phase` toggles. `blink_phase`=1 is the "off" half.
- **Decode at digit i** (all outputs registered, updated only on `tick`):
  - BCD 0-9 uses the standard patterns, active-low form: 0=0xC0, 1=0xF9, 2=0xA4, 3=0xB0, 4=0x99, 5=0x92, 6=0x82, 7=0xF8, 8=0x80, 9=0x98.
  - Codes 10-15 show a dash, 0xBF.
  - `dp_in[i]`=1 clears bit 7.
- **Blanking.** Digit i shows all segments off, dp included (0xFF), if either:
  - `blink_mask[i]` and `blink_phase`, or
  - `blank_lead`, i < NUM_DIGITS-1, and digits 0..i are all zero.

  The rightmost digit is never lead-blanked. A blanked digit still gets its `SSEGD` slot, so scan timing is unchanged.
- **Enables.** `SSEGD` is one-hot on the slot digit. Exactly one digit is enabled after the first tick.
- **Colon.** `SSEG_COL` lit = `colon_en` && !(`colon_blink` && `blink_phase`). It updates on `tick`.
- **Polarity.** With `ACTIVE_LOW`=0, all three outputs are bitwise inverted at the register input.

## Timing
- **Reset values.** `rst_n` low forces immediately:
  - `SSEG` to unlit (0xFF for ACTIVE_LOW=1)
  - `SSEGD` to all unlit
  - `SSEG_COL` to unlit
  - `div_cnt`, `scan_idx`, `blink_cnt`, `blink_phase` and `shadow` to 0

  Reset mid-scan blanks the display in the same instant, with no wait for a clock edge.
- **First update.** The first output update is on the SCAN_DIV-th rising edge after `rst_n` deasserts, showing digit 0.
- **Slot length.** Each digit slot is exactly SCAN_DIV cycles. A frame is NUM_DIGITS*SCAN_DIV cycles.
- **Blink period.** One blink half-period is BLINK_DIV frames. The first toggle occurs at the frame start that begins frame BLINK_DIV (0-based).
- **Latency.** An input change reaches the pins at the next frame start, at most one frame later.
- **Single digit.** With NUM_DIGITS=1, every tick is a frame start. `SSEGD` stays constantly lit after the first tick.
- **Widths.** Counter widths are $clog2 of their bound, minimum 1 bit.

## Structure
- **Package `sseg_pkg`:**
  - segment pattern constants: digits 0-9, DASH=0xBF, BLANK=0xFF
  - localparam bit positions (DP=7)
  - pure function `bcd_to_seg(logic [3:0])` returning the active-low pattern
- **Sub-module `sseg_decode`:** combinational. Inputs are BCD, dp, blank and ACTIVE_LOW. Output is the final 8-bit pattern. The top instantiates it once, on the muxed slot digit.
- **Top:** divider, scan index, blink counter, shadow register, lead-zero prefix logic and output registers.

## Test plan
1. **Reset and first update.** Hold `rst_n`=0 -> `SSEG`=0xFF, `SSEGD`=4'hF, `SSEG_COL` unlit. Release with SCAN_DIV=4 and digits 1,2,3,4 -> 4th edge gives `SSEGD`=1110, `SSEG`=0xF9.
2. **Scan order.** Same setup, run 2 frames -> 1110/0xF9, 1101/0xA4, 1011/0xB0, 0111/0x99, 4 cycles each, then repeat. Assert one-hot enable every cycle.
3. **Blink.** `blink_mask`=0010, BLINK_DIV=2, digits 1,2,3,4 -> digit 1 shows 0xA4 in frames 0-1, 0xFF in frames 2-3, 0xA4 in frames 4-5. `colon_blink`=1 toggles `SSEG_COL` on the same boundaries.
4. **Blanking and codes.**
   - `blank_lead`=1, digits 0,0,4,5 -> 0xFF, 0xFF, 0x99, 0x92.
   - Digits 0,0,0,0 -> 0xFF, 0xFF, 0xFF, 0xC0.
   - Digit 0xC with `dp_in[2]`=1 -> slot 2 shows 0x3F.
5. **Frame-consistent capture.** Change `digits_in` while digit 2 is displayed -> digits 2-3 keep the old values. All new values appear from the next digit-0 slot.
6. **Async reset mid-frame.** Drive `rst_n` low between clock edges -> outputs go to unlit before the next edge. After release, the scan restarts at digit 0 after SCAN_DIV edges.
